// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the single-cycle control decoder.
// Contents:
//   - opcode constants understood by the decoder
//   - fetch FSM state encoding
//   - default reset PC
//   - branch displacement helper (sign-extended word offset, in bytes)
package fetch_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   // 16-bit word displacement -> 32-bit byte displacement.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// next_pc_logic: purely combinational next-PC selection.
// Ports:
//   pc_plus4 [31:0]  address of the sequentially following instruction
//   inst     [31:0]  current instruction (jump target / branch immediate)
//   branch, bne, jump, zero  decoder controls and ALU zero flag
//   next_pc  [31:0]  committed PC when the current instruction retires
// Jump beats branch; a branch is taken when zero differs from bne, so BEQ
// takes on zero and BNE takes on non-zero. All arithmetic wraps mod 2^32.
module next_pc_logic
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] inst,
   input  logic        branch,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic taken;
   logic unused_opcode;

   assign taken = branch & (zero ^ bne);
   // The opcode field is decoded elsewhere; it plays no part in the target.
   assign unused_opcode = ^inst[31:26];

   // NOTE: every output of an always_comb gets a default on entry so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
      end else if (taken) begin
         next_pc = pc_plus4 + branch_offset(inst[15:0]);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the single-cycle decoder.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata  ready-handshaked instruction memory port
//   inst, inst_valid           registered instruction and its holding flag
//   advance                    core has executed inst; commit next PC
//   branch, bne, jump, zero    next-PC controls, sampled only on advance
//   pc, pc_plus4               current instruction address and pc + 4
//   inst_count                 retired-instruction counter (wraps)
// Sequence: one IDLE cycle after reset, then FETCH until the memory is
// ready, then HOLD until the core advances, then FETCH again.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        inst,
   output logic               inst_valid,
   input  logic               advance,
   input  logic               branch,
   input  logic               bne,
   input  logic               jump,
   input  logic               zero,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic [COUNT_W-1:0] inst_count
);

   fetch_state_e       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        inst_q, inst_d;
   logic               inst_valid_q, inst_valid_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [31:0]        next_pc;

   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign inst_count = count_q;

   next_pc_logic u_next_pc (
      .pc_plus4 (pc_plus4),
      .inst     (inst_q),
      .branch   (branch),
      .bne      (bne),
      .jump     (jump),
      .zero     (zero),
      .next_pc  (next_pc)
   );

   // imem_req is decoded from the state register, so it drops the moment
   // reset asserts and an in-flight request is abandoned.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      count_d      = count_q;
      imem_req     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (advance) begin
               pc_d         = next_pc;
               inst_valid_d = 1'b0;
               count_d      = count_q + COUNT_W'(1);
               state_d      = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= 32'h0;
         inst_valid_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         count_q      <= count_d;
      end
   end

endmodule
